// File: rtl/reg_bank_writer.sv
// Bank of 32 x WIDTH registers with byte-enabled writes, a write counter and a
// sequential clear engine. Register 0 is hardwired to zero.
module reg_bank_writer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4:0]            wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [WIDTH/8-1:0]    wr_be,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic [32*WIDTH-1:0]   regs_out,
    output logic [15:0]           wr_count
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [4:0]         clr_idx;
    logic [4:0]         clr_idx_nxt;
    logic               ready_en;
    logic               wr_accept;
    logic               wr_counted;
    logic [WIDTH-1:0]   regs [32];

    // ready_en holds wr_ready low for the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            clr_idx  <= 5'd1;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_idx  <= clr_idx_nxt;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        wr_ready    = 1'b0;
        clr_busy    = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = ready_en;
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_idx_nxt = 5'd1;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (clr_idx == 5'd31) begin
                    state_nxt   = IDLE;
                    clr_idx_nxt = 5'd1;
                end else begin
                    clr_idx_nxt = clr_idx + 5'd1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                clr_idx_nxt = 5'd1;
            end
        endcase
    end

    assign wr_accept  = wr_valid && wr_ready;
    assign wr_counted = wr_accept && (wr_addr != 5'd0) && (wr_be != '0);

    // Writes and clearing are mutually exclusive since wr_ready is low in CLEAR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[clr_idx] <= '0;
        end else if (wr_accept && (wr_addr != 5'd0)) begin
            for (int unsigned b = 0; b < WIDTH/8; b++) begin
                if (wr_be[b]) begin
                    regs[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count <= '0;
        end else if (wr_counted) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    always_comb begin
        regs_out = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            regs_out[i*WIDTH +: WIDTH] = regs[i];
        end
    end

endmodule

// File: tb/tb_reg_bank_writer.sv
// Randomized self-checking bench for reg_bank_writer against an array-based
// reference model of the register bank, counter and clear sweep.
module tb_reg_bank_writer;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;
    logic          clr_req;
    logic          clr_busy;
    logic [1023:0] regs_out;
    logic [15:0]   wr_count;

    always #5 clk = ~clk;

    reg_bank_writer #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .regs_out (regs_out),
        .wr_count (wr_count)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] m_regs [32];
    int unsigned m_count;
    bit          m_up;
    bit          m_clearing;
    int unsigned m_clr_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_count    = 0;
        m_up       = 0;
        m_clearing = 0;
        m_clr_done = 0;
    endfunction

    // One rising edge with reset_n high, using the inputs present before it.
    function automatic void model_edge();
        bit accept;
        accept = wr_valid && m_up && !m_clearing;
        if (m_clearing) begin
            m_regs[m_clr_done + 1] = '0;
            m_clr_done++;
            if (m_clr_done == 31) m_clearing = 0;
        end else if (clr_req) begin
            m_clearing = 1;
            m_clr_done = 0;
        end
        if (accept && wr_addr != 0) begin
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) m_regs[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            if (wr_be != 0) m_count = (m_count + 1) % 65536;
        end
        m_up = 1;
    endfunction

    task automatic check_all();
        check_eq("wr_ready", {31'd0, wr_ready}, {31'd0, m_up && !m_clearing});
        check_eq("clr_busy", {31'd0, clr_busy}, {31'd0, m_clearing});
        check_eq("wr_count", {16'd0, wr_count}, m_count);
        for (int i = 0; i < 32; i++)
            check_eq($sformatf("reg%0d", i), regs_out[32*i +: 32], m_regs[i]);
    endtask

    task automatic step(input bit full);
        @(posedge clk);
        model_edge();
        #1;
        if (full) check_all();
    endtask

    task automatic drive_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_be    = '0;
        clr_req  = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all();
        end
        reset_n = 1'b1;

        // First edge after release must not accept a write.
        drive_write(5'd3, 32'h12345678, 4'hF);
        step(1);

        drive_write(5'd5, 32'hDEADBEEF, 4'hF);
        step(1);
        check_eq("req033_reg5", regs_out[191:160], 32'hDEADBEEF);
        check_eq("req033_cnt", {16'd0, wr_count}, 32'd1);

        drive_write(5'd5, 32'h11223344, 4'h5);
        step(1);
        check_eq("req034_reg5", regs_out[191:160], 32'hDE22BE44);
        check_eq("req034_cnt", {16'd0, wr_count}, 32'd2);

        drive_write(5'd0, 32'hFFFFFFFF, 4'hF);
        step(1);
        check_eq("req035_reg0", regs_out[31:0], 32'd0);
        check_eq("req035_cnt", {16'd0, wr_count}, 32'd2);
        check_eq("req035_rdy", {31'd0, wr_ready}, 32'd1);

        // Back-to-back writes to one address, last wins.
        drive_write(5'd9, 32'hAAAA_0001, 4'hF);
        step(1);
        drive_write(5'd9, 32'hBBBB_0002, 4'hF);
        step(1);

        // Random traffic with occasional clears and writes attempted during clears.
        for (int n = 0; n < 400; n++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            wr_be    = 4'($urandom_range(0, 15));
            clr_req  = ($urandom_range(0, 49) == 0);
            step(1);
        end
        clr_req  = 1'b0;
        wr_valid = 1'b0;
        while (m_clearing) step(1);

        // Fill every register, then a full clear with writes hammering throughout.
        for (int a = 1; a < 32; a++) begin
            drive_write(5'(a), $urandom | 32'h1, 4'hF);
            step(1);
        end
        wr_valid = 1'b0;
        clr_req  = 1'b1;
        step(1);
        clr_req  = 1'b0;
        for (int c = 0; c < 31; c++) begin
            drive_write(5'($urandom_range(1, 31)), 32'hFFFFFFFF, 4'hF);
            check_eq("req036_busy", {31'd0, clr_busy}, 32'd1);
            step(1);
        end
        wr_valid = 1'b0;
        check_eq("req036_idle", {31'd0, clr_busy}, 32'd0);
        check_eq("req036_img_lo", regs_out[31:0] | regs_out[63:32] | regs_out[1023:992], 32'd0);

        // Same-edge write and clear request.
        drive_write(5'd7, 32'hA5A5A5A5, 4'hF);
        clr_req = 1'b1;
        step(1);
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        check_eq("req037_reg7_wr", regs_out[255:224], 32'hA5A5A5A5);
        repeat (31) step(1);
        check_eq("req037_reg7", regs_out[255:224], 32'd0);

        // Reset asserted in the middle of a clear.
        for (int a = 1; a < 32; a++) begin
            drive_write(5'(a), 32'hC0DE0000 | a, 4'hF);
            step(0);
        end
        wr_valid = 1'b0;
        clr_req  = 1'b1;
        step(1);
        clr_req  = 1'b0;
        repeat (9) step(1);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;

        // Drive the counter to its wrap point.
        drive_write(5'd1, 32'h0, 4'h1);
        for (int n = 0; n < 70000 && m_count != 65535; n++) begin
            wr_data = $urandom;
            step(0);
        end
        check_all();
        check_eq("req038_cnt_max", {16'd0, wr_count}, 32'h0000FFFF);
        step(1);
        check_eq("req038_cnt_wrap", {16'd0, wr_count}, 32'd0);
        wr_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank_writer.md
REG_BANK_WRITER -- requirements
Module: reg_bank_writer

Interface
REQ-001 Parameter: WIDTH, 32, data width of each register; the only supported value is 32.
REQ-002 Port: clk  input  1  single clock for the block; all state changes on the rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: wr_valid  input  1  write request valid.
REQ-005 Port: wr_ready  output  1  block can accept a write this cycle.
REQ-006 Port: wr_addr  input  5  target register index, 0..31.
REQ-007 Port: wr_data  input  32  write data.
REQ-008 Port: wr_be  input  4  byte enables; bit k enables wr_data[8k+7:8k].
REQ-009 Port: clr_req  input  1  request to zero all registers sequentially.
REQ-010 Port: clr_busy  output  1  high while the sequential clear is running.
REQ-011 Port: regs_out  output  1024  flat register image; register i is on bits [32i+31:32i], for direct connection to 32-input read muxes.
REQ-012 Port: wr_count  output  16  count of writes that changed a register.

Function
REQ-013 The block SHALL hold 32 registers of 32 bits; register 0 SHALL always read as 0.
REQ-014 The FSM SHALL have exactly two states, IDLE and CLEAR.
REQ-015 In IDLE, wr_ready SHALL be 1. In CLEAR, wr_ready SHALL be 0.
REQ-016 A write SHALL be accepted on a rising edge where wr_valid=1 and wr_ready=1; wr_valid with wr_ready=0 SHALL be ignored and not queued.
REQ-017 On an accepted write to address 1..31, each byte with wr_be bit=1 SHALL take the matching wr_data byte; bytes with wr_be bit=0 SHALL hold their value.
REQ-018 The result of an accepted write SHALL appear on regs_out in the cycle after the accepting edge (latency 1).
REQ-019 An accepted write to address 0 SHALL complete the handshake and SHALL change no state.
REQ-020 wr_count SHALL increment by 1 on each accepted write with address != 0 and wr_be != 0.
REQ-021 wr_count SHALL wrap from 0xFFFF to 0x0000.
REQ-022 clr_req=1 in IDLE SHALL move the FSM to CLEAR on the next edge and set the clear index to 1.
REQ-023 In CLEAR, each edge SHALL zero the register at the clear index and increment the index.
REQ-024 After zeroing register 31, the FSM SHALL return to IDLE; CLEAR lasts exactly 31 cycles.
REQ-025 clr_busy SHALL be 1 exactly while in CLEAR.
REQ-026 clr_req SHALL be ignored while in CLEAR.
REQ-027 Clearing SHALL NOT change wr_count.
REQ-028 If wr_valid and clr_req are both 1 in IDLE on the same edge, the write SHALL be accepted (and counted) on that edge, CLEAR SHALL begin on the following cycle, and the written register (if nonzero index) SHALL be zeroed by the clear.
REQ-029 Back-to-back accepted writes to the same address SHALL apply in order; the last write wins.

Reset
REQ-030 While reset_n=0: all registers SHALL be 0, wr_count=0, FSM=IDLE, clear index=1, clr_busy=0 and wr_ready=0.
REQ-031 The first rising edge after reset_n returns high SHALL accept no write; from the next cycle, wr_ready=1.
REQ-032 Asserting reset_n=0 during CLEAR SHALL abort the clear immediately and apply the REQ-030 values.

Verification
REQ-033 Reset release, then write addr=5, data=0xDEADBEEF, be=0xF -> regs_out[191:160]=0xDEADBEEF the next cycle; wr_count=1.
REQ-034 Register 5 = 0xDEADBEEF, then write addr=5, data=0x11223344, be=0x5 -> register 5 = 0xDE22BE44; wr_count=2.
REQ-035 Write addr=0, data=0xFFFFFFFF, be=0xF -> regs_out[31:0]=0; wr_count unchanged; wr_ready stays 1.
REQ-036 Fill registers 1..31 with nonzero data, pulse clr_req -> clr_busy=1 and wr_ready=0 for 31 cycles; register i reads 0 from clear cycle i onward; all registers 0 after IDLE returns; wr_valid during CLEAR is ignored.
REQ-037 Same-edge wr_valid (addr=7, data=0xA5A5A5A5) and clr_req -> wr_count increments; register 7 reads 0 after the clear completes.
REQ-038 Start a clear, assert reset_n=0 at clear cycle 10 -> all outputs take reset values immediately; write wr_count to 0xFFFF then one more counted write -> wr_count=0x0000.
